i2c_rxff: RTL and testbench
===========================

# i2c_rxff

I2C receive FIFO: buffers bytes deserialized by the I2C shift/control core until software reads them over APB. It mirrors the transmit FIFO in the other direction: the I2C core is the writer, the APB register block is the reader. It is 16 × 8 bits with first-word-fall-through read data, fill level, threshold flag, sticky overflow and a flush on the rising edge of the receive-control bit.

## Interface
Parameters: none. Depth is fixed at 16, width at 8, and pointers are 5 bits (4 address bits plus a wrap bit).

Ports:
- pclk  in  1  system/APB clock; all state is on the rising edge.
- prst_n  in  1  reset, asynchronous, active-low.
- i_data  in  8  received byte from the I2C core.
- i_rxff_wr  in  1  write strobe from the I2C core, one pulse per byte.
- apb_rxff_rd  in  1  pop strobe from the APB read of the RX data register, one pulse per access.
- apb_crx  in  1  receive-control bit; its rising edge flushes the FIFO.
- apb_ov_clr  in  1  single-cycle pulse; clears the overflow flag.
- apb_rxtl  in  4  threshold level.
- rxff_data  out  8  head entry; 8'h00 when empty.
- rxff_empty  out  1  FIFO holds 0 entries.
- rxff_full  out  1  FIFO holds 16 entries; the I2C core uses it to stretch SCL.
- rxff_rxne  out  1  not empty (~rxff_empty).
- rxff_level  out  5  number of entries, 0..16.
- rxff_thr  out  1  asserted when rxff_level > apb_rxtl.
- rxff_ov  out  1  sticky overflow flag.

## Operation
- **Pointers.**
  - rxff_wptr and rxff_rptr are 5 bits wide and wrap modulo 32.
  - Storage is addressed by pointer[3:0].
  - empty = (wptr == rptr).
  - full = (wptr[4] != rptr[4]) && (wptr[3:0] == rptr[3:0]).
  - level = wptr − rptr, a 5-bit modular subtraction.
- **Write.**
  - Accepted when i_rxff_wr=1 and (!full or read accepted in the same cycle).
  - An accepted write stores i_data at wptr[3:0] and increments wptr.
- **Read.**
  - Accepted when apb_rxff_rd=1 and !empty; an accepted read increments rptr.
  - A read on an empty FIFO is ignored: no pointer change and no flag.
- **Simultaneous read and write.**
  - Both are performed and the level is unchanged.
  - When full, the write is accepted because the read frees a slot; no overflow.
  - When empty, the read is ignored and the write is accepted, so the level becomes 1.
- **Overflow.**
  - Set when i_rxff_wr=1, full=1 and no read is accepted in that cycle.
  - The incoming byte is dropped; memory and wptr are unchanged.
  - rxff_ov stays set until an apb_ov_clr pulse or a flush.
  - If a set condition and apb_ov_clr occur in the same cycle, set wins.
- **Flush.**
  - apb_crx is registered into apb_crx1; flush = apb_crx & ~apb_crx1.
  - On flush: wptr ← 0, rptr ← 0, rxff_ov ← 0.
  - Flush has priority over any same-cycle read, write or overflow. The write is discarded and no overflow is recorded.
  - Memory contents are not cleared.
- **Memory.** Plain registers with no reset; only accepted writes modify them.
- **Status outputs.** All are combinational decodes of the pointer registers; rxff_ov is a register. No output depends combinationally on the strobes.

## Timing
- **Reset values.** wptr=0, rptr=0, apb_crx1=0, rxff_ov=0. Therefore rxff_empty=1, rxff_full=0, rxff_rxne=0, rxff_level=0, rxff_data=8'h00. rxff_thr is 0 for any apb_rxtl.
- **Write latency.** A write accepted at edge N is visible at N+: level+1, rxne=1, and rxff_data updated if this is the first entry.
- **Read latency.** A read accepted at edge N makes the next entry (or 8'h00) appear on rxff_data after edge N. The APB block samples rxff_data in the same cycle it asserts apb_rxff_rd.
- **Back-to-back.** One write and one read per cycle are sustained indefinitely.
- **Overflow timing.** rxff_ov rises at the edge following the rejected write.
- **Flush timing.** Flush takes effect at the edge where apb_crx is first sampled high after being low. A held-high apb_crx causes only one flush.
- **Reset mid-operation.** Asynchronous reset immediately returns all outputs to reset values, independent of pclk.

## Test plan
- **Reset and empty read.** Assert prst_n=0 mid-stream, then release; pulse apb_rxff_rd once. Required: level=0, empty=1, rxff_data=8'h00, rptr unchanged, ov=0.
- **Fill, overflow and clear.** Write bytes 8'h01..8'h10 (16 writes), then write 8'hAA. Required: full=1, level=16, ov=1 one cycle later, and 8'hAA is never read. Then read 16 times: required data 01..10 in order. Then pulse apb_ov_clr: required ov=0.
- **Wrap-around.** Repeat 20 cycles of write k followed by read (k=0x30..0x43) so the pointers pass 16. Required: every read returns its matching byte, level ≤ 1, and empty=1 at the end.
- **Simultaneous at boundaries.**
  - Full FIFO, same-cycle write 8'h55 and read. Required: head is popped, level stays 16, ov=0, and 8'h55 is read last.
  - Empty FIFO, same-cycle write 8'h77 and read. Required: level=1, rxff_data=8'h77.
- **Threshold.** Set apb_rxtl=4 and write 5 bytes. Required: rxff_thr=0 at level 4 and 1 at level 5; it deasserts after one read.
- **Flush priority.** With level=7 and ov=1, raise apb_crx in the same cycle as a write and a read, and hold it high 3 cycles. Required: level=0, ov=0, exactly one flush, and the write is discarded.

Source files
------------

// File: rtl/i2c_rxff.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_rxff
//  Description : I2C receive FIFO, 16 x 8, first-word-fall-through. The I2C
//                core pushes received bytes and the APB register block pops
//                them. Provides fill level, threshold flag, sticky overflow
//                and a flush on the rising edge of the receive-control bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_rxff (
  input  logic       pclk,
  input  logic       prst_n,
  input  logic [7:0] i_data,
  input  logic       i_rxff_wr,
  input  logic       apb_rxff_rd,
  input  logic       apb_crx,
  input  logic       apb_ov_clr,
  input  logic [3:0] apb_rxtl,
  output logic [7:0] rxff_data,
  output logic       rxff_empty,
  output logic       rxff_full,
  output logic       rxff_rxne,
  output logic [4:0] rxff_level,
  output logic       rxff_thr,
  output logic       rxff_ov
);

  localparam int unsigned c_DEPTH = 16;

  // Pointers carry one wrap bit above the 4 address bits so that full and
  // empty can be told apart when the address bits match.
  logic [4:0] r_wptr;
  logic [4:0] r_rptr;
  logic       r_crx1;
  logic       r_ov;
  logic [7:0] r_mem [0:c_DEPTH-1];

  logic       w_empty;
  logic       w_full;
  logic [4:0] w_level;
  logic       w_flush;
  logic       w_rd_ok;
  logic       w_wr_ok;
  logic       w_ov_set;

  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[4] != r_rptr[4]) && (r_wptr[3:0] == r_rptr[3:0]);
  assign w_level  = r_wptr - r_rptr;
  assign w_flush  = apb_crx & ~r_crx1;

  // A pop on an empty FIFO is silently ignored. A push into a full FIFO is
  // still taken if a pop frees a slot in the same cycle.
  assign w_rd_ok  = apb_rxff_rd & ~w_empty;
  assign w_wr_ok  = i_rxff_wr & (~w_full | w_rd_ok);
  assign w_ov_set = i_rxff_wr & w_full & ~w_rd_ok;

  // Edge detector for the receive-control bit; a held-high bit flushes once.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) r_crx1 <= 1'b0;
    else         r_crx1 <= apb_crx;
  end

  // Pointer update; flush overrides any same-cycle push or pop.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      r_wptr <= 5'd0;
      r_rptr <= 5'd0;
    end else if (w_flush) begin
      r_wptr <= 5'd0;
      r_rptr <= 5'd0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + 5'd1;
      if (w_rd_ok) r_rptr <= r_rptr + 5'd1;
    end
  end

  // Sticky overflow: set beats clear, flush beats both.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n)         r_ov <= 1'b0;
    else if (w_flush)    r_ov <= 1'b0;
    else if (w_ov_set)   r_ov <= 1'b1;
    else if (apb_ov_clr) r_ov <= 1'b0;
  end

  // Storage array has no reset; a write discarded by flush leaves it alone.
  always_ff @(posedge pclk) begin
    if (w_wr_ok && !w_flush) r_mem[r_wptr[3:0]] <= i_data;
  end

  assign rxff_data  = w_empty ? 8'h00 : r_mem[r_rptr[3:0]];
  assign rxff_empty = w_empty;
  assign rxff_full  = w_full;
  assign rxff_rxne  = ~w_empty;
  assign rxff_level = w_level;
  assign rxff_thr   = (w_level > {1'b0, apb_rxtl});
  assign rxff_ov    = r_ov;

endmodule
`default_nettype wire

// File: tb/tb_i2c_rxff.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_rxff
//  Description : Directed self-checking bench for the I2C receive FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_rxff;

  logic       pclk;
  logic       prst_n;
  logic [7:0] i_data;
  logic       i_rxff_wr;
  logic       apb_rxff_rd;
  logic       apb_crx;
  logic       apb_ov_clr;
  logic [3:0] apb_rxtl;
  logic [7:0] rxff_data;
  logic       rxff_empty;
  logic       rxff_full;
  logic       rxff_rxne;
  logic [4:0] rxff_level;
  logic       rxff_thr;
  logic       rxff_ov;

  int n_vec;
  int n_err;

  i2c_rxff dut (
    .pclk        (pclk),
    .prst_n      (prst_n),
    .i_data      (i_data),
    .i_rxff_wr   (i_rxff_wr),
    .apb_rxff_rd (apb_rxff_rd),
    .apb_crx     (apb_crx),
    .apb_ov_clr  (apb_ov_clr),
    .apb_rxtl    (apb_rxtl),
    .rxff_data   (rxff_data),
    .rxff_empty  (rxff_empty),
    .rxff_full   (rxff_full),
    .rxff_rxne   (rxff_rxne),
    .rxff_level  (rxff_level),
    .rxff_thr    (rxff_thr),
    .rxff_ov     (rxff_ov)
  );

  // 100 MHz clock
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Single comparison point: counts every check and reports mismatches
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of strobes; inputs change 1ns after the active edge
  task automatic step(input logic wr, input logic [7:0] d, input logic rd);
    i_rxff_wr   = wr;
    i_data      = d;
    apb_rxff_rd = rd;
    @(posedge pclk);
    #1;
    i_rxff_wr   = 1'b0;
    apb_rxff_rd = 1'b0;
  endtask

  // Check head entry (FWFT) and pop it
  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, {24'd0, rxff_data}, {24'd0, exp});
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic ov_clear();
    apb_ov_clr = 1'b1;
    @(posedge pclk);
    #1;
    apb_ov_clr = 1'b0;
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    prst_n      = 1'b0;
    i_data      = 8'h00;
    i_rxff_wr   = 1'b0;
    apb_rxff_rd = 1'b0;
    apb_crx     = 1'b0;
    apb_ov_clr  = 1'b0;
    apb_rxtl    = 4'd0;
    repeat (3) @(posedge pclk);
    #1;
    prst_n = 1'b1;

    // ---- reset values
    chk("rst_level", 32'(rxff_level), 32'd0);
    chk("rst_empty", 32'(rxff_empty), 32'd1);
    chk("rst_full",  32'(rxff_full),  32'd0);
    chk("rst_rxne",  32'(rxff_rxne),  32'd0);
    chk("rst_data",  32'(rxff_data),  32'd0);
    chk("rst_ov",    32'(rxff_ov),    32'd0);
    chk("rst_thr",   32'(rxff_thr),   32'd0);

    // ---- asynchronous reset mid-stream, then empty read
    step(1'b1, 8'hC1, 1'b0);
    step(1'b1, 8'hC2, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    chk("pre_rst_level", 32'(rxff_level), 32'd3);
    #2 prst_n = 1'b0;
    #1;
    chk("async_rst_level", 32'(rxff_level), 32'd0);
    chk("async_rst_data",  32'(rxff_data),  32'd0);
    @(posedge pclk);
    #1 prst_n = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    chk("empty_rd_level", 32'(rxff_level), 32'd0);
    chk("empty_rd_empty", 32'(rxff_empty), 32'd1);
    chk("empty_rd_data",  32'(rxff_data),  32'd0);
    chk("empty_rd_ov",    32'(rxff_ov),    32'd0);

    // ---- fill, overflow and clear
    for (int k = 1; k <= 16; k++) step(1'b1, 8'(k), 1'b0);
    chk("fill_full",  32'(rxff_full),  32'd1);
    chk("fill_level", 32'(rxff_level), 32'd16);
    chk("fill_ov",    32'(rxff_ov),    32'd0);
    chk("fill_rxne",  32'(rxff_rxne),  32'd1);
    step(1'b1, 8'hAA, 1'b0);
    chk("ovf_ov",    32'(rxff_ov),    32'd1);
    chk("ovf_level", 32'(rxff_level), 32'd16);
    for (int k = 1; k <= 16; k++) pop_chk("fill_pop", 8'(k));
    chk("drain_empty", 32'(rxff_empty), 32'd1);
    chk("drain_data",  32'(rxff_data),  32'd0);
    chk("drain_ov",    32'(rxff_ov),    32'd1);
    ov_clear();
    chk("ov_clr", 32'(rxff_ov), 32'd0);

    // ---- wrap-around (pointers start at 16)
    for (int k = 8'h30; k <= 8'h43; k++) begin
      step(1'b1, 8'(k), 1'b0);
      chk("wrap_level1", 32'(rxff_level), 32'd1);
      pop_chk("wrap_pop", 8'(k));
      chk("wrap_level0", 32'(rxff_level), 32'd0);
    end
    chk("wrap_empty", 32'(rxff_empty), 32'd1);

    // ---- simultaneous read/write on a full FIFO
    for (int k = 0; k < 16; k++) step(1'b1, 8'(8'hB0 + k), 1'b0);
    chk("sim_full_pre", 32'(rxff_full), 32'd1);
    chk("sim_full_head", 32'(rxff_data), 32'hB0);
    step(1'b1, 8'h55, 1'b1);
    chk("sim_full_level", 32'(rxff_level), 32'd16);
    chk("sim_full_ov",    32'(rxff_ov),    32'd0);
    for (int k = 1; k < 16; k++) pop_chk("sim_full_pop", 8'(8'hB0 + k));
    pop_chk("sim_full_last", 8'h55);
    chk("sim_full_empty", 32'(rxff_empty), 32'd1);

    // ---- simultaneous read/write on an empty FIFO
    step(1'b1, 8'h77, 1'b1);
    chk("sim_empty_level", 32'(rxff_level), 32'd1);
    chk("sim_empty_data",  32'(rxff_data),  32'h77);
    pop_chk("sim_empty_pop", 8'h77);
    chk("sim_empty_end", 32'(rxff_empty), 32'd1);

    // ---- threshold
    apb_rxtl = 4'd4;
    for (int k = 0; k < 4; k++) step(1'b1, 8'(8'hD0 + k), 1'b0);
    chk("thr_lvl4", 32'(rxff_thr), 32'd0);
    step(1'b1, 8'hD4, 1'b0);
    chk("thr_lvl5_level", 32'(rxff_level), 32'd5);
    chk("thr_lvl5", 32'(rxff_thr), 32'd1);
    pop_chk("thr_pop", 8'hD0);
    chk("thr_after_rd", 32'(rxff_thr), 32'd0);
    for (int k = 1; k < 5; k++) pop_chk("thr_drain", 8'(8'hD0 + k));
    apb_rxtl = 4'd0;

    // ---- flush priority: level 7 with overflow pending
    for (int k = 0; k < 16; k++) step(1'b1, 8'(8'hE0 + k), 1'b0);
    step(1'b1, 8'hAB, 1'b0);
    for (int k = 0; k < 9; k++) pop_chk("fl_pre_pop", 8'(8'hE0 + k));
    chk("fl_pre_level", 32'(rxff_level), 32'd7);
    chk("fl_pre_ov",    32'(rxff_ov),    32'd1);
    apb_crx = 1'b1;
    step(1'b1, 8'hEE, 1'b1);
    chk("fl_level", 32'(rxff_level), 32'd0);
    chk("fl_ov",    32'(rxff_ov),    32'd0);
    chk("fl_empty", 32'(rxff_empty), 32'd1);
    chk("fl_data",  32'(rxff_data),  32'd0);
    step(1'b1, 8'h61, 1'b0);
    chk("fl_hold1_level", 32'(rxff_level), 32'd1);
    chk("fl_hold1_data",  32'(rxff_data),  32'h61);
    step(1'b1, 8'h62, 1'b0);
    chk("fl_hold2_level", 32'(rxff_level), 32'd2);
    chk("fl_hold2_data",  32'(rxff_data),  32'h61);
    apb_crx = 1'b0;
    pop_chk("fl_pop0", 8'h61);
    pop_chk("fl_pop1", 8'h62);
    chk("fl_end_empty", 32'(rxff_empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
